// File: rtl/roi_capture_ctrl.sv
// ROI capture controller: arms on request or continuously, writes one ROI frame into a
// ping-pong buffer bank, validates completeness and hands full banks to inference in order.
module roi_capture_ctrl #(
  parameter int unsigned ROI_W  = 112,
  parameter int unsigned ROI_H  = 112,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              i_pixel_clk,
  input  logic              i_rst,
  input  logic              i_cfg_continuous,
  input  logic              i_capture_req,
  input  logic              i_frame_vsync,
  input  logic              i_roi_valid,
  input  logic [6:0]        i_roi_x,
  input  logic [6:0]        i_roi_y,
  input  logic [15:0]       i_roi_pixel,
  output logic              o_buf_we,
  output logic              o_buf_bank,
  output logic [ADDR_W-1:0] o_buf_addr,
  output logic [15:0]       o_buf_wdata,
  output logic              o_infer_start,
  output logic              o_infer_bank,
  input  logic              i_infer_done,
  output logic              o_busy,
  output logic              o_capture_err,
  output logic [7:0]        o_frames_dropped
);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StCommit} state_e;

  localparam int unsigned       NumPix   = ROI_W * ROI_H;
  localparam logic [ADDR_W-1:0] LastCnt  = ADDR_W'(NumPix - 1);
  localparam logic [31:0]       RoiWBits = 32'(ROI_W);

  state_e              r_state, w_state_nxt;
  logic                r_vs_d;
  logic                r_wr_bank, w_wr_bank_nxt;
  logic                r_req_pend;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [1:0]          r_full, w_full_nxt;
  logic                r_oldest, w_oldest_nxt;
  logic                r_infer_active;
  logic                r_infer_bank;
  logic                r_buf_we;
  logic                r_buf_bank;
  logic [ADDR_W-1:0]   r_buf_addr;
  logic [15:0]         r_buf_wdata;
  logic                r_capture_err;
  logic [7:0]          r_frames_dropped;

  logic                w_frame_start;
  logic                w_last_pix;
  logic                w_wr_en;
  logic                w_req_clr;
  logic                w_cnt_clr;
  logic                w_commit;
  logic                w_cap_err;
  logic                w_drop;
  logic                w_infer_start;
  logic                w_sel;
  logic                w_done;
  logic [ADDR_W-1:0]   w_addr;

  assign w_frame_start = i_frame_vsync & ~r_vs_d;
  assign w_last_pix    = i_roi_valid && (i_roi_x == 7'(ROI_W - 1)) && (i_roi_y == 7'(ROI_H - 1));
  assign w_wr_en       = (r_state == StCapture) && i_roi_valid && !w_frame_start;
  assign w_drop        = (r_state == StIdle) && i_cfg_continuous && (&r_full) && w_frame_start;

  // Constant-coefficient multiply unrolled into shifted adds of the row index.
  always_comb begin
    w_addr = ADDR_W'(i_roi_x);
    for (int b = 0; b < 32; b++) begin
      if (RoiWBits[b]) w_addr = w_addr + (ADDR_W'(i_roi_y) << b);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_bank_nxt = r_wr_bank;
    w_req_clr     = 1'b0;
    w_cnt_clr     = 1'b0;
    w_commit      = 1'b0;
    w_cap_err     = 1'b0;
    case (r_state)
      StIdle: begin
        if ((r_req_pend || i_cfg_continuous) && !(&r_full)) begin
          w_state_nxt   = StArm;
          w_wr_bank_nxt = r_full[0];
          w_req_clr     = 1'b1;
        end
      end
      StArm: begin
        if (w_frame_start) begin
          w_state_nxt = StCapture;
          w_cnt_clr   = 1'b1;
        end
      end
      StCapture: begin
        // A new frame start before the last pixel abandons this frame; the bank is kept.
        if (w_frame_start) begin
          w_cap_err   = 1'b1;
          w_state_nxt = StArm;
        end else if (w_last_pix) begin
          if (r_pix_cnt == LastCnt) begin
            w_state_nxt = StCommit;
          end else begin
            w_cap_err   = 1'b1;
            w_state_nxt = StArm;
          end
        end
      end
      StCommit: begin
        w_commit = 1'b1;
        if (i_cfg_continuous && !r_full[~r_wr_bank]) begin
          w_state_nxt   = StArm;
          w_wr_bank_nxt = ~r_wr_bank;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_infer_start = !r_infer_active && (|r_full);
  assign w_sel         = r_full[r_oldest] ? r_oldest : ~r_oldest;
  assign w_done        = i_infer_done && r_infer_active;

  // With at most one full bank it is by definition the oldest; with two, the pointer holds.
  always_comb begin
    w_full_nxt = r_full;
    if (w_done) w_full_nxt[r_infer_bank] = 1'b0;
    if (w_commit) w_full_nxt[r_wr_bank] = 1'b1;
    w_oldest_nxt = r_oldest;
    if (w_full_nxt == 2'b01) begin
      w_oldest_nxt = 1'b0;
    end else if (w_full_nxt == 2'b10) begin
      w_oldest_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_rst) begin
      r_state          <= StIdle;
      r_vs_d           <= 1'b0;
      r_wr_bank        <= 1'b0;
      r_req_pend       <= 1'b0;
      r_pix_cnt        <= '0;
      r_full           <= 2'b00;
      r_oldest         <= 1'b0;
      r_infer_active   <= 1'b0;
      r_infer_bank     <= 1'b0;
      r_buf_we         <= 1'b0;
      r_buf_bank       <= 1'b0;
      r_buf_addr       <= '0;
      r_buf_wdata      <= '0;
      r_capture_err    <= 1'b0;
      r_frames_dropped <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vs_d        <= i_frame_vsync;
      r_wr_bank     <= w_wr_bank_nxt;
      r_req_pend    <= (r_req_pend & ~w_req_clr) | i_capture_req;
      r_full        <= w_full_nxt;
      r_oldest      <= w_oldest_nxt;
      r_capture_err <= w_cap_err;
      r_buf_we      <= w_wr_en;
      if (w_cnt_clr) begin
        r_pix_cnt <= '0;
      end else if (w_wr_en) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      if (w_wr_en) begin
        r_buf_bank  <= r_wr_bank;
        r_buf_addr  <= w_addr;
        r_buf_wdata <= i_roi_pixel;
      end
      if (w_infer_start) begin
        r_infer_active <= 1'b1;
        r_infer_bank   <= w_sel;
      end else if (w_done) begin
        r_infer_active <= 1'b0;
      end
      if (w_drop && (r_frames_dropped != 8'hff)) begin
        r_frames_dropped <= r_frames_dropped + 1'b1;
      end
    end
  end

  assign o_buf_we         = r_buf_we;
  assign o_buf_bank       = r_buf_bank;
  assign o_buf_addr       = r_buf_addr;
  assign o_buf_wdata      = r_buf_wdata;
  assign o_infer_start    = w_infer_start;
  assign o_infer_bank     = w_infer_start ? w_sel : r_infer_bank;
  assign o_busy           = (r_state != StIdle);
  assign o_capture_err    = r_capture_err;
  assign o_frames_dropped = r_frames_dropped;

endmodule

// File: tb/tb_roi_capture_ctrl.sv
// Directed scenarios with randomized pixel data, gaps and dropouts; the write log and hand-off
// order are compared against raster arithmetic and per-scenario expectations.
module tb_roi_capture_ctrl;

  localparam int unsigned W    = 112;
  localparam int unsigned H    = 16;
  localparam int unsigned AW   = 14;
  localparam int unsigned NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_cont;
  logic          cap_req;
  logic          vsync;
  logic          roi_valid;
  logic [6:0]    roi_x;
  logic [6:0]    roi_y;
  logic [15:0]   roi_pixel;
  logic          infer_done;
  logic          buf_we;
  logic          buf_bank;
  logic [AW-1:0] buf_addr;
  logic [15:0]   buf_wdata;
  logic          infer_start;
  logic          infer_bank;
  logic          busy;
  logic          capture_err;
  logic [7:0]    frames_dropped;

  always #5 clk = ~clk;

  roi_capture_ctrl #(.ROI_W(W), .ROI_H(H), .ADDR_W(AW)) dut (
    .i_pixel_clk      (clk),
    .i_rst            (rst),
    .i_cfg_continuous (cfg_cont),
    .i_capture_req    (cap_req),
    .i_frame_vsync    (vsync),
    .i_roi_valid      (roi_valid),
    .i_roi_x          (roi_x),
    .i_roi_y          (roi_y),
    .i_roi_pixel      (roi_pixel),
    .o_buf_we         (buf_we),
    .o_buf_bank       (buf_bank),
    .o_buf_addr       (buf_addr),
    .o_buf_wdata      (buf_wdata),
    .o_infer_start    (infer_start),
    .o_infer_bank     (infer_bank),
    .i_infer_done     (infer_done),
    .o_busy           (busy),
    .o_capture_err    (capture_err),
    .o_frames_dropped (frames_dropped)
  );

  int n_vec = 0;
  int n_err = 0;

  // Observed activity, logged away from the clock edge.
  logic          w_bank[$];
  logic [AW-1:0] w_addr[$];
  logic [15:0]   w_data[$];
  logic          ev_bank[$];
  int            n_cerr = 0;

  // Pixels the bench delivered, in raster-arithmetic form.
  int            e_addr[$];
  logic [15:0]   e_data[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_we) begin
        w_bank.push_back(buf_bank);
        w_addr.push_back(buf_addr);
        w_data.push_back(buf_wdata);
      end
      if (infer_start) ev_bank.push_back(infer_bank);
      if (capture_err) n_cerr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    cfg_cont   = 1'b0;
    cap_req    = 1'b0;
    vsync      = 1'b0;
    roi_valid  = 1'b0;
    roi_x      = '0;
    roi_y      = '0;
    roi_pixel  = '0;
    infer_done = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic request();
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    idle(2);
  endtask

  task automatic pulse_done();
    infer_done = 1'b1;
    tick();
    infer_done = 1'b0;
  endtask

  // Frame start, then the first stop_at raster pixels with n_drop random non-final dropouts.
  task automatic send_frame(input int stop_at, input int n_drop);
    bit          skip[NPIX];
    int          cnt;
    int          k;
    logic [15:0] pix;
    for (int i = 0; i < NPIX; i++) skip[i] = 1'b0;
    cnt = 0;
    while (cnt < n_drop) begin
      k = $urandom_range(0, NPIX - 2);
      if (!skip[k]) begin
        skip[k] = 1'b1;
        cnt++;
      end
    end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int i = 0; i < stop_at; i++) begin
      if ($urandom_range(0, 7) == 0) tick();
      pix       = 16'($urandom);
      roi_x     = 7'(i % W);
      roi_y     = 7'(i / W);
      roi_pixel = pix;
      roi_valid = !skip[i];
      if (!skip[i]) begin
        e_addr.push_back((i / W) * W + (i % W));
        e_data.push_back(pix);
      end
      tick();
      roi_valid = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int wm, input int em, input logic bank);
    int n;
    int e0;
    n = e_addr.size() - em;
    chk({tag, "_count"}, 32'(w_addr.size() - wm), 32'(n));
    if (w_addr.size() - wm == n) begin
      e0 = n_err;
      for (int i = 0; i < n; i++) begin
        chk({tag, "_write"}, 32'({w_bank[wm+i], w_addr[wm+i], w_data[wm+i]}),
            32'({bank, AW'(e_addr[em+i]), e_data[em+i]}));
        if (n_err != e0) break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wm, em, eb, cb;

    // Single capture on request.
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_buf_we", 32'(buf_we), 0);
    chk("rst_infer", 32'({infer_start, infer_bank}), 0);
    chk("rst_err", 32'(capture_err), 0);
    chk("rst_dropped", 32'(frames_dropped), 0);
    request();
    chk("s1_armed", 32'(busy), 1);
    wm = w_addr.size(); em = e_addr.size(); eb = ev_bank.size(); cb = n_cerr;
    send_frame(NPIX, 0);
    chk("s1_commit_no_start", 32'(infer_start), 0);
    tick();
    chk("s1_start", 32'({infer_start, infer_bank}), 32'(2'b10));
    chk("s1_idle", 32'(busy), 0);
    tick();
    chk("s1_start_pulse", 32'({infer_start, infer_bank}), 0);
    check_frame("s1", wm, em, 1'b0);
    if (w_addr.size() > wm + 229) chk("s1_addr_x5y2", 32'(w_addr[wm+229]), 229);
    chk("s1_ev_count", 32'(ev_bank.size() - eb), 1);
    chk("s1_no_err", 32'(n_cerr - cb), 0);
    pulse_done();

    // Ping-pong with inference held off.
    do_reset();
    cfg_cont = 1'b1;
    idle(3);
    chk("s2_armed", 32'(busy), 1);
    wm = w_addr.size(); em = e_addr.size(); eb = ev_bank.size();
    send_frame(NPIX, 0);
    idle(3);
    check_frame("s2a", wm, em, 1'b0);
    wm = w_addr.size(); em = e_addr.size();
    send_frame(NPIX, 0);
    idle(3);
    check_frame("s2b", wm, em, 1'b1);
    chk("s2_idle_full", 32'(busy), 0);
    chk("s2_ev_first", 32'(ev_bank.size() - eb), 1);
    if (ev_bank.size() > eb) chk("s2_ev_bank0", 32'(ev_bank[eb]), 0);
    wm = w_addr.size();
    send_frame(50, 0);
    idle(2);
    chk("s2_drop_no_write", 32'(w_addr.size() - wm), 0);
    chk("s2_dropped", 32'(frames_dropped), 1);
    pulse_done();
    chk("s2_start_bank1", 32'({infer_start, infer_bank}), 32'(2'b11));
    idle(2);
    chk("s2_rearm", 32'(busy), 1);
    wm = w_addr.size(); em = e_addr.size();
    send_frame(NPIX, 0);
    idle(3);
    check_frame("s2d", wm, em, 1'b0);
    chk("s2_ev_total", 32'(ev_bank.size() - eb), 2);
    chk("s2_idle_again", 32'(busy), 0);
    chk("s2_dropped_hold", 32'(frames_dropped), 1);

    // Truncated frame followed by a new frame start.
    do_reset();
    request();
    eb = ev_bank.size(); cb = n_cerr;
    send_frame(8 * W, 0);
    idle(4);
    chk("s3_no_err_yet", 32'(n_cerr - cb), 0);
    send_frame(0, 0);
    idle(2);
    chk("s3_err", 32'(n_cerr - cb), 1);
    chk("s3_still_armed", 32'(busy), 1);
    chk("s3_no_start", 32'(ev_bank.size() - eb), 0);
    wm = w_addr.size(); em = e_addr.size();
    send_frame(NPIX, 0);
    idle(3);
    check_frame("s3_restart", wm, em, 1'b0);
    chk("s3_ev_count", 32'(ev_bank.size() - eb), 1);
    if (ev_bank.size() > eb) chk("s3_ev_bank0", 32'(ev_bank[eb]), 0);
    chk("s3_err_total", 32'(n_cerr - cb), 1);

    // Ten missing pixels.
    do_reset();
    request();
    wm = w_addr.size(); eb = ev_bank.size(); cb = n_cerr;
    send_frame(NPIX, 10);
    chk("s4_err_pulse", 32'(capture_err), 1);
    tick();
    chk("s4_err_single", 32'(capture_err), 0);
    idle(5);
    chk("s4_err_count", 32'(n_cerr - cb), 1);
    chk("s4_writes", 32'(w_addr.size() - wm), 32'(NPIX - 10));
    chk("s4_no_start", 32'(ev_bank.size() - eb), 0);
    chk("s4_rearmed", 32'(busy), 1);

    // Commit of bank 1 coincides with release of bank 0.
    do_reset();
    cfg_cont = 1'b1;
    idle(3);
    eb = ev_bank.size();
    send_frame(NPIX, 0);
    idle(3);
    chk("s5_first_ev", 32'(ev_bank.size() - eb), 1);
    wm = w_addr.size(); em = e_addr.size();
    send_frame(NPIX, 0);
    pulse_done();
    chk("s5_start_bank1", 32'({infer_start, infer_bank}), 32'(2'b11));
    tick();
    chk("s5_start_pulse", 32'(infer_start), 0);
    chk("s5_rearm_bank0", 32'(busy), 1);
    check_frame("s5", wm, em, 1'b1);

    // Reset partway through a capture.
    do_reset();
    request();
    send_frame(1000, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_buf_we", 32'(buf_we), 0);
    chk("s6_busy", 32'(busy), 0);
    chk("s6_infer", 32'(infer_start), 0);
    chk("s6_err", 32'(capture_err), 0);
    wm = w_addr.size(); eb = ev_bank.size();
    send_frame(300, 0);
    idle(20);
    chk("s6_no_write", 32'(w_addr.size() - wm), 0);
    chk("s6_no_start", 32'(ev_bank.size() - eb), 0);
    chk("s6_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
